// File: rtl/aes128_pkg.sv
// Shared AES-128 tables, GF(2^8) helpers, FSM state type and size constants.
package aes128_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;
    localparam int BLK_W = 128;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

    // Byte x lives at bits [2047-8x -: 8]; each 128-bit row covers 16 entries.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_mul2(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes128_inv_cipher_if.sv
// Start/result bundle of the AES-128 inverse cipher: key and ciphertext in, plaintext and status out.
interface aes128_inv_cipher_if;
    import aes128_pkg::*;

    logic [KEY_W-1:0] cipher_key;
    logic [BLK_W-1:0] cipher_text;
    logic             decipher_en;
    logic [BLK_W-1:0] plain_text;
    logic             decipher_ready;
    logic             decipher_busy;

    modport master (
        output cipher_key, cipher_text, decipher_en,
        input  plain_text, decipher_ready, decipher_busy
    );

    modport slave (
        input  cipher_key, cipher_text, decipher_en,
        output plain_text, decipher_ready, decipher_busy
    );

endinterface

// File: rtl/aes128_key_step.sv
// One AES-128 key-schedule step, forward (dir=0) or backward (dir=1).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module aes128_key_step
    import aes128_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    input  logic [7:0]       rcon,
    input  logic             dir,
    output logic [KEY_W-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] b0, b1, b2, b3;

    assign {w0, w1, w2, w3} = key_in;

    assign f0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    // Undo the chained XORs first so b3 equals the previous key's last word.
    assign b3 = w3 ^ w2;
    assign b2 = w2 ^ w1;
    assign b1 = w1 ^ w0;
    assign b0 = w0 ^ sub_word(rot_word(b3)) ^ {rcon, 24'h0};

    assign key_out = dir ? {b0, b1, b2, b3} : {f0, f1, f2, f3};

endmodule

// File: rtl/aes128_inv_cipher_top.sv
// Iterative AES-128 decryption, one round per clock; optional rk10 cache via AES128_INV_KEY_CACHE_EN.
// Latency: 20 clocks from accepted start to ready (10 on a cache hit).
// Backpressure: starts are dropped while busy; result holds until the next accepted start.
module aes128_inv_cipher_top
    import aes128_pkg::*;
(
    input  logic                clk_sys,
    input  logic                rst,
    aes128_inv_cipher_if.slave  bus
);

    localparam logic [3:0] LAST_KEY  = 4'(NR);
    localparam logic [3:0] FIRST_RND = 4'(NR - 1);

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic [BLK_W-1:0] data_q;
    logic [KEY_W-1:0] key_q;
    logic [BLK_W-1:0] pt_q;

    logic             start_acc;
    logic             cache_hit;
    logic [KEY_W-1:0] hit_rk10;
    logic             ks_dir;
    logic [7:0]       ks_rcon;
    logic [KEY_W-1:0] ks_out;
    logic [BLK_W-1:0] isb, ark, imc, round_out;

    assign start_acc = bus.decipher_en && (state == IDLE || state == DONE);

`ifdef AES128_INV_KEY_CACHE_EN
    logic             cache_vld;
    logic [KEY_W-1:0] cache_key;
    logic [KEY_W-1:0] cache_rk10;

    assign cache_hit = cache_vld && (bus.cipher_key == cache_key);
    assign hit_rk10  = cache_rk10;

    // Key is captured at the start of a miss; rk10 and the valid flag land when KEYEXP ends.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cache_vld  <= 1'b0;
            cache_key  <= '0;
            cache_rk10 <= '0;
        end else if (start_acc && !cache_hit) begin
            cache_vld <= 1'b0;
            cache_key <= bus.cipher_key;
        end else if (state == KEYEXP && cnt == LAST_KEY) begin
            cache_vld  <= 1'b1;
            cache_rk10 <= ks_out;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_rk10  = '0;
`endif

    // During ROUND the register holds rk[cnt+1]; stepping back with Rcon[cnt+1] yields rk[cnt].
    assign ks_dir  = (state == ROUND);
    assign ks_rcon = rcon(ks_dir ? cnt + 4'd1 : cnt);

    aes128_key_step u_key_step (
        .key_in  (key_q),
        .rcon    (ks_rcon),
        .dir     (ks_dir),
        .key_out (ks_out)
    );

    always_comb begin
        isb = '0;
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isb[127 - 8*(r + 4*c) -: 8] = inv_sbox(data_q[127 - 8*(r + 4*((c - r) & 3)) -: 8]);
            end
        end
        ark = isb ^ ks_out;
        for (int c = 0; c < 4; c++) begin
            imc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
        end
        round_out = (cnt == 4'd0) ? ark : imc;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_acc) state_nxt = cache_hit ? ROUND : KEYEXP;
            KEYEXP:     if (cnt == LAST_KEY) state_nxt = ROUND;
            ROUND:      if (cnt == 4'd0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            data_q <= '0;
            key_q  <= '0;
            pt_q   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_acc) begin
                        if (cache_hit) begin
                            data_q <= bus.cipher_text ^ hit_rk10;
                            key_q  <= hit_rk10;
                            cnt    <= FIRST_RND;
                        end else begin
                            data_q <= bus.cipher_text;
                            key_q  <= bus.cipher_key;
                            cnt    <= 4'd1;
                        end
                    end
                end
                KEYEXP: begin
                    key_q <= ks_out;
                    if (cnt == LAST_KEY) begin
                        data_q <= data_q ^ ks_out;
                        cnt    <= FIRST_RND;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    key_q  <= ks_out;
                    data_q <= round_out;
                    if (cnt == 4'd0) pt_q <= round_out;
                    else             cnt  <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.plain_text     = pt_q;
    assign bus.decipher_ready = (state == DONE);
    assign bus.decipher_busy  = (state == KEYEXP) || (state == ROUND);

endmodule
